noc_credit_link: RTL and testbench
==================================

// Module: noc_credit_link
// PURPOSE
//  Router-to-router link stage: consumes one router output port (data/dest/is_tail/send) and
//  drives the neighbour router's input port, returning that router's credits upstream.
//  Inserts NUM_PIPELINE register stages on the forward flit path and on the credit return path.
//  Monitors credit accounting and wormhole framing on the link and raises sticky error flags.
// PARAMETERS
//  NUM_PIPELINE       0    register stages per direction (0 = combinational pass-through)
//  FLIT_WIDTH         128  flit payload width
//  DEST_WIDTH         6    dest field width (TDEST_WIDTH + TID_WIDTH)
//  FLIT_BUFFER_DEPTH  4    downstream input buffer depth = upstream credit pool size
// PORTS
//  clk_noc       in   1            NoC clock; all state on rising edge
//  rst_n         in   1            synchronous, active-low reset
//  data_in       in   FLIT_WIDTH   flit from upstream router output
//  dest_in       in   DEST_WIDTH   destination of flit
//  is_tail_in    in   1            last flit of packet
//  send_in       in   1            flit valid this cycle
//  credit_out    out  1            credit returned to upstream router
//  data_out      out  FLIT_WIDTH   flit to downstream router input
//  dest_out      out  DEST_WIDTH
//  is_tail_out   out  1
//  send_out      out  1
//  credit_in     in   1            credit from downstream router
//  err_credit    out  1            sticky: send with zero credits, or credit beyond pool
//  err_framing   out  1            sticky: dest changed inside a packet
//  flit_count    out  32           flits accepted (see CONFIGURATION)
//  pkt_count     out  32           tail flits accepted (see CONFIGURATION)
// BEHAVIOUR
//  - Forward: {send,data,dest,is_tail} delayed exactly NUM_PIPELINE cycles; only send bits reset
//    (to 0); data/dest/is_tail stages are not reset. No backpressure; every flit is forwarded.
//  - Credit: credit_in delayed exactly NUM_PIPELINE cycles to credit_out; credit stages reset to 0.
//  - NUM_PIPELINE=0: outputs equal inputs combinationally; monitors still active.
//  - Reset values: send_out=0, credit_out=0, err_*=0, counters=0, FSM=IDLE, cnt=FLIT_BUFFER_DEPTH.
//  - Credit monitor (upstream view): cnt width $clog2(FLIT_BUFFER_DEPTH+1).
//    send_in&~credit_out: cnt-1; credit_out&~send_in: cnt+1; both or neither: hold.
//    send_in when cnt==0 -> err_credit=1 (even if credit_out same cycle); cnt holds at 0.
//    credit_out&~send_in when cnt==FLIT_BUFFER_DEPTH -> err_credit=1; cnt holds at max.
//  - Framing FSM on send_in flits: IDLE: send&~tail -> BODY, latch dest_in; send&tail -> IDLE
//    (single-flit packet). BODY: send&dest_in!=latched -> err_framing=1; send&tail -> IDLE.
//  - Error flags set the cycle after the offending input and clear only on reset.
//  - Reset mid-packet: in-flight pipeline flits dropped (send cleared), FSM to IDLE, cnt reloaded.
// CONFIGURATION
//  NOC_LINK_STATS_EN defined: flit_count += 1 per send_in, pkt_count += 1 per send_in&is_tail_in;
//    both saturate at 32'hFFFF_FFFF, reset to 0.
//  Not defined: counter logic omitted; flit_count and pkt_count tied to 0 (ports always present).
// STRUCTURE
//  noc_link_pkg: link_state_e {LINK_IDLE, LINK_BODY}; typedef flit_fields_t
//    {is_tail, dest, data} parameterised via widths in the module; STATS_WIDTH=32.
//  Sub-module noc_link_pipe: generic N-stage delay (N=0 pass-through) with resettable valid bit
//    and non-reset payload; instantiated once forward (payload=flit_fields_t) and once for credit
//    (payload width 0, valid only).
// TESTING
//  1 NUM_PIPELINE=2: send 3-flit packet dest=6'h05, tail on 3rd -> identical flits on outputs
//    2 cycles later, errors 0, pkt_count=1, flit_count=3 (STATS_EN).
//  2 Send 4 flits with no credit_in, then 5th -> err_credit=1 the cycle after the 5th send.
//  3 Credit while cnt==FLIT_BUFFER_DEPTH (no prior sends) -> err_credit=1; simultaneous
//    send+credit at cnt=2 -> cnt stays 2, no error.
//  4 Head dest=6'h03, body dest=6'h07 -> err_framing=1; single-flit packets back-to-back with
//    differing dest -> no error.
//  5 Reset asserted mid-packet with flits in pipeline -> send_out=0 next cycle, no stale flit
//    after release, cnt=FLIT_BUFFER_DEPTH, errors clear.
//  6 NUM_PIPELINE=0: same-cycle pass-through of send and credit; without NOC_LINK_STATS_EN counters read 0.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the NoC credit link stage.
// The flit field struct depends on module parameters, so it is declared
// inside noc_credit_link rather than here.
package noc_link_pkg;

  // Wormhole framing state seen on the upstream side of the link
  typedef enum logic {
    LINK_IDLE = 1'b0,
    LINK_BODY = 1'b1
  } link_state_e;

  localparam int STATS_WIDTH = 32;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
    return (&value) ? value : value + STATS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/noc_credit_link_if.sv
// Router port bundle: one flit per cycle forward, one credit pulse backward.
//
// Handshake: send qualifies data/dest/is_tail for exactly one cycle and there
// is no ready signal. Flow control is credit based: the sender may only assert
// send while it holds a credit, and the receiver pulses credit for one cycle
// each time it frees one input buffer slot.
interface noc_credit_link_if #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEST_WIDTH = 6
);
  logic [FLIT_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;
  logic                  is_tail;
  logic                  send;
  logic                  credit;

  // Router output port side: drives flits, receives credits
  modport master (
    output data, dest, is_tail, send,
    input  credit
  );

  // Router input port side: receives flits, returns credits
  modport slave (
    input  data, dest, is_tail, send,
    output credit
  );
endinterface

// File: rtl/noc_link_pipe.sv
// Generic N-stage delay line with a resettable valid bit and a non-reset
// payload. N=0 is a combinational pass-through. W=0 carries valid only;
// the payload port then stays one bit wide and drives zero.
module noc_link_pipe #(
  parameter int N = 0,
  parameter int W = 1,
  localparam int PW = (W > 0) ? W : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [PW-1:0] payload_in,
  output logic          valid_out,
  output logic [PW-1:0] payload_out
);

  if (N == 0) begin : g_bypass
    assign valid_out = valid_in;
    if (W > 0) begin : g_pay
      assign payload_out = payload_in;
    end else begin : g_nopay
      logic unused_payload;
      assign unused_payload = ^payload_in;
      assign payload_out    = '0;
    end
  end else begin : g_stages
    logic [N-1:0] valid_q;

    // Valid bits shift one stage per cycle and clear on reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= valid_in;
        for (int i = 1; i < N; i++) begin
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign valid_out = valid_q[N-1];

    if (W > 0) begin : g_pay
      logic [PW-1:0] payload_q [N];

      // Payload follows valid but is never reset; valid alone qualifies it
      always_ff @(posedge clk) begin
        payload_q[0] <= payload_in;
        for (int i = 1; i < N; i++) begin
          payload_q[i] <= payload_q[i-1];
        end
      end

      assign payload_out = payload_q[N-1];
    end else begin : g_nopay
      logic unused_payload;
      assign unused_payload = ^payload_in;
      assign payload_out    = '0;
    end
  end

endmodule

// File: rtl/noc_credit_link.sv
// Router-to-router link stage. Delays flits downstream and credits upstream
// by NUM_PIPELINE cycles each, and watches the upstream side for credit
// accounting and wormhole framing violations (sticky error flags).
// Optional statistics counters are built when NOC_LINK_STATS_EN is defined;
// otherwise flit_count and pkt_count read zero.
// link_state and credit_cnt expose the monitor state for debug.
module noc_credit_link
  import noc_link_pkg::*;
#(
  parameter int NUM_PIPELINE      = 0,
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 4,
  localparam int CNT_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  noc_credit_link_if.slave       up,
  noc_credit_link_if.master      down,
  output logic                   err_credit,
  output logic                   err_framing,
  output logic [STATS_WIDTH-1:0] flit_count,
  output logic [STATS_WIDTH-1:0] pkt_count,
  output link_state_e            link_state,
  output logic [CNT_WIDTH-1:0]   credit_cnt
);

  typedef struct packed {
    logic                  is_tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } flit_fields_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  flit_fields_t fwd_in;
  flit_fields_t fwd_out;
  logic         credit_ret;
  logic         unused_credit_payload;

  assign fwd_in = '{is_tail: up.is_tail, dest: up.dest, data: up.data};

  noc_link_pipe #(
    .N (NUM_PIPELINE),
    .W ($bits(flit_fields_t))
  ) u_fwd_pipe (
    .clk         (clk_noc),
    .rst_n       (rst_n),
    .valid_in    (up.send),
    .payload_in  (fwd_in),
    .valid_out   (down.send),
    .payload_out (fwd_out)
  );

  assign down.data    = fwd_out.data;
  assign down.dest    = fwd_out.dest;
  assign down.is_tail = fwd_out.is_tail;

  noc_link_pipe #(
    .N (NUM_PIPELINE),
    .W (0)
  ) u_credit_pipe (
    .clk         (clk_noc),
    .rst_n       (rst_n),
    .valid_in    (down.credit),
    .payload_in  (1'b0),
    .valid_out   (credit_ret),
    .payload_out (unused_credit_payload)
  );

  assign up.credit = credit_ret;

  // ---------------------------------------------------------------------------
  // Credit monitor: models the upstream router's credit pool as it sees it,
  // i.e. sends leave here and credits arrive after the return pipeline.
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 credit_fault;

  assign credit_fault = (up.send && (cnt_q == '0)) ||
                        (credit_ret && !up.send && (cnt_q == CNT_MAX));

  // Track available credits, clamped at empty and full
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      cnt_q <= CNT_MAX;
    end else if (up.send && !credit_ret && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (credit_ret && !up.send && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Latch any credit violation until reset
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      err_credit <= 1'b0;
    end else if (credit_fault) begin
      err_credit <= 1'b1;
    end
  end

  assign credit_cnt = cnt_q;

  // ---------------------------------------------------------------------------
  // Framing monitor: every flit of a multi-flit packet must carry the head's
  // destination.
  // ---------------------------------------------------------------------------
  link_state_e           state_q;
  link_state_e           state_d;
  logic                  framing_fault;
  logic [DEST_WIDTH-1:0] head_dest_q;

  // Framing state register
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      state_q <= LINK_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and dest-consistency check
  always_comb begin
    state_d       = state_q;
    framing_fault = 1'b0;
    case (state_q)
      LINK_IDLE: begin
        if (up.send && !up.is_tail) begin
          state_d = LINK_BODY;
        end
      end
      LINK_BODY: begin
        if (up.send) begin
          if (up.dest != head_dest_q) begin
            framing_fault = 1'b1;
          end
          if (up.is_tail) begin
            state_d = LINK_IDLE;
          end
        end
      end
    endcase
  end

  // Capture the head flit's destination when a multi-flit packet opens
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      head_dest_q <= '0;
    end else if ((state_q == LINK_IDLE) && up.send && !up.is_tail) begin
      head_dest_q <= up.dest;
    end
  end

  // Latch any framing violation until reset
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      err_framing <= 1'b0;
    end else if (framing_fault) begin
      err_framing <= 1'b1;
    end
  end

  assign link_state = state_q;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef NOC_LINK_STATS_EN
  logic [STATS_WIDTH-1:0] flit_q;
  logic [STATS_WIDTH-1:0] pkt_q;

  // Count accepted flits and tail flits, saturating at all-ones
  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      flit_q <= '0;
      pkt_q  <= '0;
    end else if (up.send) begin
      flit_q <= sat_inc(flit_q);
      if (up.is_tail) begin
        pkt_q <= sat_inc(pkt_q);
      end
    end
  end

  assign flit_count = flit_q;
  assign pkt_count  = pkt_q;
`else
  assign flit_count = '0;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: one instance with NUM_PIPELINE=0 (index 0) and
// one with NUM_PIPELINE=2 (index 1), checked against a cycle-level model
// built from input history queues and integer credit/packet bookkeeping.
module tb_noc_credit_link;
  import noc_link_pkg::*;

  localparam int FW    = 32;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          rn;
    logic          send;
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
    logic          credit;
  } cyc_t;

  // ---------------- clock / reset ----------------
  logic clk_noc = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_noc = ~clk_noc;

  // ---------------- DUTs ----------------
  noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up0 ();
  noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) down0 ();
  noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) up1 ();
  noc_credit_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) down1 ();

  logic          err_c     [2];
  logic          err_f     [2];
  logic [31:0]   flit_cnt  [2];
  logic [31:0]   pkt_cnt   [2];
  logic [CW-1:0] cnt_dbg   [2];
  link_state_e   state_dbg [2];

  noc_credit_link #(.NUM_PIPELINE(0), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .up(up0), .down(down0),
    .err_credit(err_c[0]), .err_framing(err_f[0]), .flit_count(flit_cnt[0]),
    .pkt_count(pkt_cnt[0]), .link_state(state_dbg[0]), .credit_cnt(cnt_dbg[0]));

  noc_credit_link #(.NUM_PIPELINE(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut1 (
    .clk_noc(clk_noc), .rst_n(rst_n), .up(up1), .down(down1),
    .err_credit(err_c[1]), .err_framing(err_f[1]), .flit_count(flit_cnt[1]),
    .pkt_count(pkt_cnt[1]), .link_state(state_dbg[1]), .credit_cnt(cnt_dbg[1]));

  logic          obs_send   [2];
  logic [FW-1:0] obs_data   [2];
  logic [DW-1:0] obs_dest   [2];
  logic          obs_tail   [2];
  logic          obs_credit [2];

  assign obs_send[0]   = down0.send;    assign obs_send[1]   = down1.send;
  assign obs_data[0]   = down0.data;    assign obs_data[1]   = down1.data;
  assign obs_dest[0]   = down0.dest;    assign obs_dest[1]   = down1.dest;
  assign obs_tail[0]   = down0.is_tail; assign obs_tail[1]   = down1.is_tail;
  assign obs_credit[0] = up0.credit;    assign obs_credit[1] = up1.credit;

  // ---------------- reference model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  cyc_t        cur   [2];
  cyc_t        exp_o [2];
  cyc_t        hist0 [$];
  cyc_t        hist1 [$];
  int          avail    [2];
  bit          m_err_c  [2];
  bit          m_err_f  [2];
  bit          m_in_pkt [2];
  logic [DW-1:0] m_head [2];
  longint      m_flits  [2];
  longint      m_pkts   [2];

  function automatic int stages(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Fold the inputs of the cycle just clocked into the model
  function automatic void commit(input int d);
    cyc_t c;
    bit   s;
    bit   r;
    c = cur[d];
    if (!c.rn) begin
      avail[d] = DEPTH; m_err_c[d] = 0; m_err_f[d] = 0; m_in_pkt[d] = 0;
      m_head[d] = '0; m_flits[d] = 0; m_pkts[d] = 0;
      if (d == 0) hist0.delete(); else hist1.delete();
      return;
    end
    s = c.send;
    r = exp_o[d].credit;
    if (s && avail[d] == 0) m_err_c[d] = 1;
    if (r && !s && avail[d] == DEPTH) m_err_c[d] = 1;
    if (s && !r && avail[d] > 0) avail[d] = avail[d] - 1;
    if (r && !s && avail[d] < DEPTH) avail[d] = avail[d] + 1;
    if (s) begin
      if (m_in_pkt[d] && c.dest != m_head[d]) m_err_f[d] = 1;
      if (c.tail) m_in_pkt[d] = 0;
      else if (!m_in_pkt[d]) begin m_in_pkt[d] = 1; m_head[d] = c.dest; end
      m_flits[d] = m_flits[d] + 1;
      if (c.tail) m_pkts[d] = m_pkts[d] + 1;
    end
    if (d == 0) begin
      hist0.push_front(c);
      if (hist0.size() > 4) hist0.delete(hist0.size() - 1);
    end else begin
      hist1.push_front(c);
      if (hist1.size() > 4) hist1.delete(hist1.size() - 1);
    end
  endfunction

  // What the output side should show in the current cycle
  function automatic cyc_t delayed(input int d, input cyc_t now);
    int n;
    n = stages(d);
    if (n == 0) return now;
    if (d == 0) begin
      if (hist0.size() >= n) return hist0[n-1];
    end else begin
      if (hist1.size() >= n) return hist1[n-1];
    end
    return '0;
  endfunction

  function automatic logic [31:0] exp_flits(input int d);
`ifdef NOC_LINK_STATS_EN
    return 32'(m_flits[d]);
`else
    return 32'(m_flits[d] & 0);
`endif
  endfunction

  function automatic logic [31:0] exp_pkts(input int d);
`ifdef NOC_LINK_STATS_EN
    return 32'(m_pkts[d]);
`else
    return 32'(m_pkts[d] & 0);
`endif
  endfunction

  function automatic link_state_e exp_state(input int d);
    return m_in_pkt[d] ? LINK_BODY : LINK_IDLE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input cyc_t c);
    if (d == 0) begin
      up0.send = c.send; up0.data = c.data; up0.dest = c.dest; up0.is_tail = c.tail; down0.credit = c.credit;
    end else begin
      up1.send = c.send; up1.data = c.data; up1.dest = c.dest; up1.is_tail = c.tail; down1.credit = c.credit;
    end
  endtask

  // One clock cycle: inputs for link `sel`, the other link idles; reset is shared
  task automatic step(input int sel, input logic rv, input logic s, input logic [FW-1:0] dat,
                      input logic [DW-1:0] dst, input logic t, input logic cr);
    cyc_t c;
    @(negedge clk_noc);
    commit(0);
    commit(1);
    rst_n = rv;
    for (int d = 0; d < 2; d++) begin
      c = '0;
      c.rn = rv;
      if (d == sel) begin
        c.send = s; c.data = dat; c.dest = dst; c.tail = t; c.credit = cr;
      end
      cur[d] = c;
      drive(d, c);
      exp_o[d] = delayed(d, c);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    idle(1);
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (obs_send[d] !== 1'b0) begin n_bad++; $display("FAIL reset_send d%0d: got %b want 0", d, obs_send[d]); end
      n_cmp++; if (obs_credit[d] !== 1'b0) begin n_bad++; $display("FAIL reset_credit d%0d: got %b want 0", d, obs_credit[d]); end
      n_cmp++; if (err_c[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err_credit d%0d: got %b want 0", d, err_c[d]); end
      n_cmp++; if (err_f[d] !== 1'b0) begin n_bad++; $display("FAIL reset_err_framing d%0d: got %b want 0", d, err_f[d]); end
      n_cmp++; if (flit_cnt[d] !== 32'd0) begin n_bad++; $display("FAIL reset_flit_count d%0d: got %0d want 0", d, flit_cnt[d]); end
      n_cmp++; if (pkt_cnt[d] !== 32'd0) begin n_bad++; $display("FAIL reset_pkt_count d%0d: got %0d want 0", d, pkt_cnt[d]); end
      n_cmp++; if (cnt_dbg[d] !== CW'(DEPTH)) begin n_bad++; $display("FAIL reset_cnt d%0d: got %0d want %0d", d, cnt_dbg[d], DEPTH); end
      n_cmp++; if (state_dbg[d] !== LINK_IDLE) begin n_bad++; $display("FAIL reset_state d%0d: got %0d want IDLE", d, state_dbg[d]); end
    end
  endtask

  task automatic test_packet();
    int seen;
    seen = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) step(1, 1'b1, 1'b1, FW'($urandom), 6'h05, (i == 2), 1'b0);
      else idle(1);
      n_cmp++; if (obs_send[1] !== exp_o[1].send) begin n_bad++; $display("FAIL pkt_send cyc%0d: got %b want %b", i, obs_send[1], exp_o[1].send); end
      if (exp_o[1].send) begin
        seen++;
        n_cmp++; if (obs_data[1] !== exp_o[1].data) begin n_bad++; $display("FAIL pkt_data cyc%0d: got %h want %h", i, obs_data[1], exp_o[1].data); end
        n_cmp++; if (obs_dest[1] !== 6'h05) begin n_bad++; $display("FAIL pkt_dest cyc%0d: got %h want 05", i, obs_dest[1]); end
        n_cmp++; if (obs_tail[1] !== exp_o[1].tail) begin n_bad++; $display("FAIL pkt_tail cyc%0d: got %b want %b", i, obs_tail[1], exp_o[1].tail); end
      end
    end
    n_cmp++; if (seen != 3) begin n_bad++; $display("FAIL pkt_flits_forwarded: got %0d want 3", seen); end
    n_cmp++; if (err_c[1] !== 1'b0 || err_f[1] !== 1'b0) begin n_bad++; $display("FAIL pkt_errors: got %b%b want 00", err_c[1], err_f[1]); end
    n_cmp++; if (flit_cnt[1] !== exp_flits(1)) begin n_bad++; $display("FAIL pkt_flit_count: got %0d want %0d", flit_cnt[1], exp_flits(1)); end
    n_cmp++; if (pkt_cnt[1] !== exp_pkts(1)) begin n_bad++; $display("FAIL pkt_pkt_count: got %0d want %0d", pkt_cnt[1], exp_pkts(1)); end
    n_cmp++; if (cnt_dbg[1] !== CW'(avail[1])) begin n_bad++; $display("FAIL pkt_cnt: got %0d want %0d", cnt_dbg[1], avail[1]); end
  endtask

  task automatic test_credit_underflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) step(1, 1'b1, 1'b1, FW'($urandom), DW'(i), 1'b1, 1'b0);
      else idle(1);
      n_cmp++; if (err_c[1] !== m_err_c[1]) begin n_bad++; $display("FAIL underflow_err cyc%0d: got %b want %b", i, err_c[1], m_err_c[1]); end
      n_cmp++; if (cnt_dbg[1] !== CW'(avail[1])) begin n_bad++; $display("FAIL underflow_cnt cyc%0d: got %0d want %0d", i, cnt_dbg[1], avail[1]); end
    end
  endtask

  task automatic test_credit_excess();
    do_reset();
    step(1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_cmp++; if (err_c[1] !== m_err_c[1]) begin n_bad++; $display("FAIL excess_err cyc%0d: got %b want %b", i, err_c[1], m_err_c[1]); end
    end
    do_reset();
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h01, 1'b1, 1'b0);
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h02, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h03, 1'b1, 1'b0);
    n_cmp++; if (obs_credit[1] !== 1'b1) begin n_bad++; $display("FAIL simul_credit_out: got %b want 1", obs_credit[1]); end
    idle(1);
    n_cmp++; if (cnt_dbg[1] !== CW'(2)) begin n_bad++; $display("FAIL simul_cnt: got %0d want 2", cnt_dbg[1]); end
    n_cmp++; if (err_c[1] !== 1'b0) begin n_bad++; $display("FAIL simul_err: got %b want 0", err_c[1]); end
  endtask

  task automatic test_framing();
    do_reset();
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h03, 1'b0, 1'b0);
    n_cmp++; if (err_f[1] !== 1'b0) begin n_bad++; $display("FAIL frame_head_err: got %b want 0", err_f[1]); end
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h07, 1'b0, 1'b0);
    n_cmp++; if (state_dbg[1] !== exp_state(1)) begin n_bad++; $display("FAIL frame_state_body: got %0d want %0d", state_dbg[1], exp_state(1)); end
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h03, 1'b1, 1'b0);
    n_cmp++; if (err_f[1] !== m_err_f[1]) begin n_bad++; $display("FAIL frame_bad_dest_err: got %b want %b", err_f[1], m_err_f[1]); end
    idle(1);
    n_cmp++; if (state_dbg[1] !== exp_state(1)) begin n_bad++; $display("FAIL frame_state_idle: got %0d want %0d", state_dbg[1], exp_state(1)); end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1, 1'b1, 1'b1, FW'($urandom), DW'(8 + i), 1'b1, 1'b0);
      else idle(1);
      n_cmp++; if (err_f[1] !== 1'b0) begin n_bad++; $display("FAIL frame_single_err cyc%0d: got %b want 0", i, err_f[1]); end
      n_cmp++; if (state_dbg[1] !== LINK_IDLE) begin n_bad++; $display("FAIL frame_single_state cyc%0d: got %0d want IDLE", i, state_dbg[1]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h09, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1, FW'($urandom), 6'h0a, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++; if (err_f[1] !== m_err_f[1]) begin n_bad++; $display("FAIL mid_err_before: got %b want %b", err_f[1], m_err_f[1]); end
    n_cmp++; if (obs_send[1] !== exp_o[1].send) begin n_bad++; $display("FAIL mid_send_inflight: got %b want %b", obs_send[1], exp_o[1].send); end
    step(1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++; if (obs_send[1] !== 1'b0) begin n_bad++; $display("FAIL mid_send_after: got %b want 0", obs_send[1]); end
    n_cmp++; if (cnt_dbg[1] !== CW'(DEPTH)) begin n_bad++; $display("FAIL mid_cnt: got %0d want %0d", cnt_dbg[1], DEPTH); end
    n_cmp++; if (err_f[1] !== 1'b0 || err_c[1] !== 1'b0) begin n_bad++; $display("FAIL mid_err_clear: got %b%b want 00", err_c[1], err_f[1]); end
    n_cmp++; if (state_dbg[1] !== LINK_IDLE) begin n_bad++; $display("FAIL mid_state: got %0d want IDLE", state_dbg[1]); end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_cmp++; if (obs_send[1] !== 1'b0) begin n_bad++; $display("FAIL mid_stale cyc%0d: got %b want 0", i, obs_send[1]); end
    end
  endtask

  task automatic test_passthrough();
    logic          s;
    logic          cr;
    logic [FW-1:0] dat;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s   = 1'($urandom_range(0, 1));
      cr  = 1'($urandom_range(0, 1));
      dat = FW'($urandom);
      step(0, 1'b1, s, dat, DW'($urandom_range(0, 3)), 1'b1, cr);
      n_cmp++; if (obs_send[0] !== s) begin n_bad++; $display("FAIL pass_send cyc%0d: got %b want %b", i, obs_send[0], s); end
      n_cmp++; if (obs_credit[0] !== cr) begin n_bad++; $display("FAIL pass_credit cyc%0d: got %b want %b", i, obs_credit[0], cr); end
      if (s) begin
        n_cmp++; if (obs_data[0] !== dat) begin n_bad++; $display("FAIL pass_data cyc%0d: got %h want %h", i, obs_data[0], dat); end
      end
    end
    idle(1);
    n_cmp++; if (flit_cnt[0] !== exp_flits(0)) begin n_bad++; $display("FAIL pass_flit_count: got %0d want %0d", flit_cnt[0], exp_flits(0)); end
    n_cmp++; if (pkt_cnt[0] !== exp_pkts(0)) begin n_bad++; $display("FAIL pass_pkt_count: got %0d want %0d", pkt_cnt[0], exp_pkts(0)); end
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 1);
      step(sel, 1'b1, ($urandom_range(0, 2) != 0), FW'($urandom), DW'($urandom_range(0, 2)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if (i == 150) do_reset();
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (obs_send[d] !== exp_o[d].send) begin n_bad++; $display("FAIL rnd_send d%0d cyc%0d: got %b want %b", d, i, obs_send[d], exp_o[d].send); end
        if (exp_o[d].send) begin
          n_cmp++;
          if ({obs_data[d], obs_dest[d], obs_tail[d]} !== {exp_o[d].data, exp_o[d].dest, exp_o[d].tail}) begin
            n_bad++; $display("FAIL rnd_flit d%0d cyc%0d: got %h/%h/%b want %h/%h/%b", d, i,
              obs_data[d], obs_dest[d], obs_tail[d], exp_o[d].data, exp_o[d].dest, exp_o[d].tail);
          end
        end
        n_cmp++; if (obs_credit[d] !== exp_o[d].credit) begin n_bad++; $display("FAIL rnd_credit d%0d cyc%0d: got %b want %b", d, i, obs_credit[d], exp_o[d].credit); end
        n_cmp++; if (err_c[d] !== m_err_c[d]) begin n_bad++; $display("FAIL rnd_err_credit d%0d cyc%0d: got %b want %b", d, i, err_c[d], m_err_c[d]); end
        n_cmp++; if (err_f[d] !== m_err_f[d]) begin n_bad++; $display("FAIL rnd_err_framing d%0d cyc%0d: got %b want %b", d, i, err_f[d], m_err_f[d]); end
        n_cmp++; if (cnt_dbg[d] !== CW'(avail[d])) begin n_bad++; $display("FAIL rnd_cnt d%0d cyc%0d: got %0d want %0d", d, i, cnt_dbg[d], avail[d]); end
        n_cmp++; if (state_dbg[d] !== exp_state(d)) begin n_bad++; $display("FAIL rnd_state d%0d cyc%0d: got %0d want %0d", d, i, state_dbg[d], exp_state(d)); end
        n_cmp++; if (flit_cnt[d] !== exp_flits(d)) begin n_bad++; $display("FAIL rnd_flit_count d%0d cyc%0d: got %0d want %0d", d, i, flit_cnt[d], exp_flits(d)); end
        n_cmp++; if (pkt_cnt[d] !== exp_pkts(d)) begin n_bad++; $display("FAIL rnd_pkt_count d%0d cyc%0d: got %0d want %0d", d, i, pkt_cnt[d], exp_pkts(d)); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      cur[d] = '0;
      exp_o[d] = '0;
      drive(d, '0);
    end
    test_reset();
    test_packet();
    test_credit_underflow();
    test_credit_excess();
    test_framing();
    test_reset_mid_packet();
    test_passthrough();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
